// File: rtl/main_memory.sv
// Word-addressed 32-bit data memory with a combinational read port and a 3x3 matrix view of words 0..8.
// Define MAIN_MEMORY_BOUNDS_CHECK_EN to reject accesses with nonzero address bits above the index.
module main_memory #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemR,
  input  logic        MemW,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] d11,
  output logic [31:0] d12,
  output logic [31:0] d13,
  output logic [31:0] d21,
  output logic [31:0] d22,
  output logic [31:0] d23,
  output logic [31:0] d31,
  output logic [31:0] d32,
  output logic [31:0] d33
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (ADDR_W < 4) begin : g_addr_w_check
    $error("main_memory: ADDR_W must be at least 4");
  end

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              unused_addr_bits;

  assign idx = addr[ADDR_W+1:2];

`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
  assign in_range = ~|addr[31:ADDR_W+2];
`else
  assign in_range = 1'b1;
`endif

  // Byte-offset bits never select anything; upper bits only matter with bounds checking.
  assign unused_addr_bits = ^{addr[1:0], addr[31:ADDR_W+2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (MemW && in_range) begin
      mem_q[idx] <= wdata;
    end
  end

  assign rdata = (MemR && in_range) ? mem_q[idx] : '0;

  assign d11 = mem_q[0];
  assign d12 = mem_q[1];
  assign d13 = mem_q[2];
  assign d21 = mem_q[3];
  assign d22 = mem_q[4];
  assign d23 = mem_q[5];
  assign d31 = mem_q[6];
  assign d32 = mem_q[7];
  assign d33 = mem_q[8];

endmodule

// File: tb/tb_main_memory.sv
// Directed self-checking bench for main_memory: reset, matrix view, read gating, read-during-write, out-of-range.
module tb_main_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemR = 1'b0;
  logic        MemW = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [31:0] d11, d12, d13, d21, d22, d23, d31, d32, d33;
  logic [31:0] dv [9];

  int checks = 0;
  int failures = 0;

  main_memory #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .MemR(MemR), .MemW(MemW), .addr(addr), .wdata(wdata),
    .rdata(rdata),
    .d11(d11), .d12(d12), .d13(d13), .d21(d21), .d22(d22), .d23(d23),
    .d31(d31), .d32(d32), .d33(d33)
  );

  always #5 clk = ~clk;

  always_comb begin
    dv[0] = d11; dv[1] = d12; dv[2] = d13;
    dv[3] = d21; dv[4] = d22; dv[5] = d23;
    dv[6] = d31; dv[7] = d32; dv[8] = d33;
  end

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemW = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    MemW = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dv[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_init d[%0d] got=%h exp=%h", i, dv[i], 32'h0);
      end
    end
  endtask

  task automatic test_matrix();
    for (int i = 0; i < 9; i++) write_word(32'(i * 4), 32'(i + 1));
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dv[i] !== 32'(i + 1)) begin
        failures++;
        $display("FAIL matrix d[%0d] got=%h exp=%h", i, dv[i], 32'(i + 1));
      end
    end
  endtask

  task automatic test_reset_clear();
    pulse_reset();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (dv[i] !== 32'h0) begin
        failures++;
        $display("FAIL reset_clear d[%0d] got=%h exp=%h", i, dv[i], 32'h0);
      end
    end
    addr = 32'h0; MemR = 1'b1; #1;
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0);
    end
    MemR = 1'b0;
  endtask

  task automatic test_read_gating();
    write_word(32'd8, 32'd3);
    addr = 32'd8; MemR = 1'b1; #1;
    checks++;
    if (rdata !== 32'd3) begin
      failures++;
      $display("FAIL read_en got=%h exp=%h", rdata, 32'd3);
    end
    MemR = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL read_gated got=%h exp=%h", rdata, 32'h0);
    end
    addr = 32'd9; MemR = 1'b1; #1;
    checks++;
    if (rdata !== 32'd3) begin
      failures++;
      $display("FAIL read_lowbits got=%h exp=%h", rdata, 32'd3);
    end
    MemR = 1'b0;
  endtask

  task automatic test_no_write();
    @(negedge clk);
    MemW = 1'b0; addr = 32'd8; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    checks++;
    if (d13 !== 32'd3) begin
      failures++;
      $display("FAIL no_write d13 got=%h exp=%h", d13, 32'd3);
    end
  endtask

  task automatic test_read_during_write();
    write_word(32'd16, 32'd5);
    @(negedge clk);
    MemR = 1'b1; MemW = 1'b1; addr = 32'd16; wdata = 32'hAA; #1;
    checks++;
    if (rdata !== 32'd5) begin
      failures++;
      $display("FAIL rdw_before got=%h exp=%h", rdata, 32'd5);
    end
    @(posedge clk); #1;
    MemW = 1'b0;
    checks++;
    if (rdata !== 32'hAA) begin
      failures++;
      $display("FAIL rdw_after got=%h exp=%h", rdata, 32'hAA);
    end
    MemR = 1'b0;
  endtask

  task automatic test_reset_priority();
    write_word(32'd0, 32'd11);
    @(negedge clk);
    rst = 1'b1; MemW = 1'b1; addr = 32'd0; wdata = 32'd7;
    @(posedge clk); #1;
    rst = 1'b0; MemW = 1'b0;
    checks++;
    if (d11 !== 32'h0) begin
      failures++;
      $display("FAIL rst_priority d11 got=%h exp=%h", d11, 32'h0);
    end
    write_word(32'd4, 32'd9);
    checks++;
    if (d12 !== 32'd9) begin
      failures++;
      $display("FAIL write_after_rst d12 got=%h exp=%h", d12, 32'd9);
    end
  endtask

  task automatic test_out_of_range();
    write_word(32'd0, 32'h22);
    write_word(32'd256, 32'h55);
    addr = 32'd256; MemR = 1'b1; #1;
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
    checks++;
    if (d11 !== 32'h22) begin
      failures++;
      $display("FAIL oob_d11 got=%h exp=%h", d11, 32'h22);
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL oob_rdata got=%h exp=%h", rdata, 32'h0);
    end
`else
    checks++;
    if (d11 !== 32'h55) begin
      failures++;
      $display("FAIL wrap_d11 got=%h exp=%h", d11, 32'h55);
    end
    checks++;
    if (rdata !== 32'h55) begin
      failures++;
      $display("FAIL wrap_rdata got=%h exp=%h", rdata, 32'h55);
    end
`endif
    MemR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_matrix();
    test_reset_clear();
    test_read_gating();
    test_no_write();
    test_read_during_write();
    test_reset_priority();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
